// File: rtl/dcache_pkg.sv
// Shared configuration, FSM state codes and field/lane helpers for the data cache.
// The helpers take field positions as arguments so any legal geometry can reuse them.
package dcache_pkg;
    localparam int DEF_XLEN           = 32;
    localparam int DEF_NUM_LINES      = 16;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int OFFSET_W           = $clog2(DEF_WORDS_PER_LINE);
    localparam int INDEX_W            = $clog2(DEF_NUM_LINES);
    localparam int TAG_W              = DEF_XLEN - INDEX_W - OFFSET_W - 2;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_FILL      = 2'd2;

    // Lane 0 sits in the most significant byte of the word.
    typedef logic [0:3][7:0] lanes_t;

    function automatic logic [DEF_XLEN-1:0] addr_field(logic [DEF_XLEN-1:0] addr, int lsb, int width);
        return (addr >> lsb) & ((DEF_XLEN'(1) << width) - DEF_XLEN'(1));
    endfunction

    function automatic logic [DEF_XLEN-1:0] word_offset(logic [DEF_XLEN-1:0] addr, int off_w);
        return addr_field(addr, 2, off_w);
    endfunction

    function automatic logic [DEF_XLEN-1:0] line_index(logic [DEF_XLEN-1:0] addr, int off_w, int idx_w);
        return addr_field(addr, 2 + off_w, idx_w);
    endfunction

    function automatic logic [DEF_XLEN-1:0] line_tag(logic [DEF_XLEN-1:0] addr, int off_w, int idx_w);
        return addr >> (2 + off_w + idx_w);
    endfunction

    function automatic logic [DEF_XLEN-1:0] lanes_to_word(lanes_t lanes);
        return lanes;
    endfunction

    function automatic lanes_t word_to_lanes(logic [DEF_XLEN-1:0] word);
        return word;
    endfunction
endpackage

// File: rtl/dcache_data_array.sv
// Word storage for the cache lines: one combinational read port and one
// synchronous write port with per-byte enables.
module dcache_data_array #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic [AW-1:0]       rd_addr,
    output logic [XLEN-1:0]     rd_data,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN/8-1:0]   wr_be,
    input  logic [XLEN-1:0]     wr_data
);
    logic [XLEN-1:0] words [DEPTH];

    assign rd_data = words[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < XLEN / 8; b++) begin
                if (wr_be[b]) words[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back / write-allocate data cache. Hits finish in the request
// cycle; misses hold mem_ready low while the line is written back and refilled.
module data_cache
    import dcache_pkg::*;
#(
    parameter int XLEN           = DEF_XLEN,
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [7:0]      mem_data_in [0:3],
    output logic [7:0]      mem_data_out [0:3],
    input  logic            mem_write_en,
    input  logic            mem_read_en,
    output logic            mem_ready,
    output logic            bk_req,
    output logic            bk_we,
    output logic [XLEN-1:0] bk_addr,
    output logic [XLEN-1:0] bk_wdata,
    input  logic [XLEN-1:0] bk_rdata,
    input  logic            bk_ack
);
    localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS = XLEN - IDX_BITS - OFF_BITS - 2;

    logic [1:0]          state;
    logic [OFF_BITS-1:0] beat;
    logic [NUM_LINES-1:0] valid, dirty;
    logic [TAG_BITS-1:0] tags [NUM_LINES];

    logic [IDX_BITS-1:0] idx;
    logic [OFF_BITS-1:0] off, rd_off, wr_off;
    logic [TAG_BITS-1:0] req_tag, bk_tag;
    logic                req, is_store, hit, last_beat, fill_done;
    logic [XLEN-1:0]     rd_word, store_word, wr_word;
    logic                wr_en;
    lanes_t              in_lanes, out_lanes;

    assign idx       = IDX_BITS'(line_index(mem_addr, OFF_BITS, IDX_BITS));
    assign off       = OFF_BITS'(word_offset(mem_addr, OFF_BITS));
    assign req_tag   = TAG_BITS'(line_tag(mem_addr, OFF_BITS, IDX_BITS));
    assign req       = mem_write_en | mem_read_en;
    assign is_store  = mem_write_en;
    assign hit       = valid[idx] && (tags[idx] == req_tag);
    assign last_beat = (beat == OFF_BITS'(WORDS_PER_LINE - 1));
    assign fill_done = (state == ST_FILL) && bk_ack && last_beat;

    assign mem_ready = (state == ST_IDLE) && (!req || hit);

    always_comb begin
        for (int i = 0; i < 4; i++) in_lanes[i] = mem_data_in[i];
        store_word = lanes_to_word(in_lanes);
        out_lanes  = word_to_lanes(rd_word);
        for (int i = 0; i < 4; i++) mem_data_out[i] = out_lanes[i];
    end

    // The read port walks the victim line during writeback, otherwise serves the core.
    assign rd_off  = (state == ST_WRITEBACK) ? beat : off;
    assign wr_off  = (state == ST_FILL) ? beat : off;
    assign wr_word = (state == ST_FILL) ? bk_rdata : store_word;
    assign wr_en   = !rst_b && (((state == ST_IDLE) && req && hit && is_store) ||
                                ((state == ST_FILL) && bk_ack));

    dcache_data_array #(
        .XLEN (XLEN),
        .DEPTH(NUM_LINES * WORDS_PER_LINE),
        .AW   (IDX_BITS + OFF_BITS)
    ) u_data (
        .clk    (clk),
        .rd_addr({idx, rd_off}),
        .rd_data(rd_word),
        .wr_en  (wr_en),
        .wr_addr({idx, wr_off}),
        .wr_be  ({(XLEN/8){1'b1}}),
        .wr_data(wr_word)
    );

    // Core holds the request stable during a miss, so idx/req_tag stay valid for every beat.
    assign bk_tag   = (state == ST_WRITEBACK) ? tags[idx] : req_tag;
    assign bk_req   = (state != ST_IDLE);
    assign bk_we    = (state == ST_WRITEBACK);
    assign bk_addr  = bk_req ? {bk_tag, idx, beat, 2'b00} : '0;
    assign bk_wdata = bk_we ? rd_word : '0;

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state <= ST_IDLE;
            beat  <= '0;
            valid <= '0;
            dirty <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req && hit && is_store) begin
                        dirty[idx] <= 1'b1;
                    end else if (req && !hit) begin
                        beat  <= '0;
                        state <= (valid[idx] && dirty[idx]) ? ST_WRITEBACK : ST_FILL;
                    end
                end
                ST_WRITEBACK: begin
                    if (bk_ack) begin
                        beat <= last_beat ? '0 : beat + 1'b1;
                        if (last_beat) state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (bk_ack) begin
                        beat <= last_beat ? '0 : beat + 1'b1;
                        if (last_beat) begin
                            valid[idx] <= 1'b1;
                            dirty[idx] <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b && fill_done) tags[idx] <= req_tag;
    end
endmodule

// File: tb/tb_data_cache.sv
// Randomised bench for data_cache: an architectural memory plus a tag-only
// cache view predict load data, stall length and writeback contents.
module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst_b;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in [0:3];
    logic [7:0]  mem_data_out [0:3];
    logic        mem_write_en, mem_read_en, mem_ready;
    logic        bk_req, bk_we, bk_ack;
    logic [31:0] bk_addr, bk_wdata, bk_rdata;

    data_cache dut (
        .clk(clk), .rst_b(rst_b), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_ready(mem_ready), .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr),
        .bk_wdata(bk_wdata), .bk_rdata(bk_rdata), .bk_ack(bk_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Backing memory: 3-cycle ack latency, preloaded with w ^ A5A5_0000.
    localparam int LAT = 3;
    logic [31:0] bmem [int];
    int          lat_cnt = 0;
    int          req_cycles = 0, we_cycles = 0, fill_acks = 0;
    logic [31:0] wb_addr [$];
    logic [31:0] wb_data [$];
    logic        p_pend = 1'b0, p_we;
    logic [31:0] p_addr, p_wd;

    function automatic logic [31:0] bval(int w);
        return bmem.exists(w) ? bmem[w] : (32'(w) ^ 32'hA5A5_0000);
    endfunction

    always @(negedge clk) begin
        bk_ack   = 1'b0;
        bk_rdata = '0;
        if (bk_req === 1'b1 && lat_cnt == LAT - 1) begin
            bk_ack = 1'b1;
            if (!bk_we) bk_rdata = bval(int'(bk_addr >> 2));
        end
    end

    always @(posedge clk) begin
        if (bk_req === 1'b1 && p_pend) begin
            checks++;
            if (bk_addr !== p_addr || bk_we !== p_we || (bk_we && bk_wdata !== p_wd)) begin
                errors++;
                $display("FAIL bk_stable addr=%h/%h we=%b/%b wdata=%h/%h", bk_addr, p_addr, bk_we, p_we, bk_wdata, p_wd);
            end
        end
        p_pend = (bk_req === 1'b1) && !bk_ack;
        p_addr = bk_addr; p_we = bk_we; p_wd = bk_wdata;
        if (bk_req === 1'b1) begin
            req_cycles++;
            if (bk_we) we_cycles++;
            if (bk_ack) begin
                lat_cnt = 0;
                if (bk_we) begin
                    bmem[int'(bk_addr >> 2)] = bk_wdata;
                    wb_addr.push_back(bk_addr);
                    wb_data.push_back(bk_wdata);
                end else fill_acks++;
            end else lat_cnt++;
        end else lat_cnt = 0;
    end

    // Reference: architectural memory plus per-line valid/dirty/tag bookkeeping.
    logic [31:0] gmem [int];
    bit          m_valid [16];
    bit          m_dirty [16];
    int          m_tag   [16];

    function automatic logic [31:0] gval(int w);
        return gmem.exists(w) ? gmem[w] : (32'(w) ^ 32'hA5A5_0000);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0; end
    endfunction

    task automatic access(input logic [31:0] a, input bit st, input bit both, input logic [31:0] d,
                          output logic [31:0] rd, output int low, output bit to);
        mem_addr     = a;
        mem_write_en = st;
        mem_read_en  = !st || both;
        for (int i = 0; i < 4; i++) mem_data_in[i] = d[31-8*i -: 8];
        low = 0; to = 0; rd = '0;
        forever begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                for (int i = 0; i < 4; i++) rd[31-8*i -: 8] = mem_data_out[i];
                break;
            end
            low++;
            if (low > 100) begin to = 1; break; end
        end
        @(posedge clk); #1;
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
    endtask

    // One core operation with model prediction; returns the observed read word.
    task automatic run_op(input string nm, input logic [31:0] a, input bit st, input bit both,
                          input logic [31:0] d, output logic [31:0] rd);
        int idx, tg, exp_low, exp_wb, old_tag, low;
        bit to;
        idx = int'((a >> 4) & 32'hF);
        tg  = int'(a >> 8);
        old_tag = m_tag[idx];
        if (m_valid[idx] && m_tag[idx] == tg) begin exp_low = 0; exp_wb = 0; end
        else if (m_valid[idx] && m_dirty[idx]) begin exp_low = 1 + 8 * LAT; exp_wb = 4; end
        else begin exp_low = 1 + 4 * LAT; exp_wb = 0; end
        wb_addr.delete(); wb_data.delete();
        access(a, st, both, d, rd, low, to);
        checks++;
        if (to || low != exp_low) begin
            errors++;
            $display("FAIL %s stall addr=%h got=%0d exp=%0d timeout=%0d", nm, a, low, exp_low, to);
        end
        if (!st) begin
            checks++;
            if (rd !== gval(int'(a >> 2))) begin
                errors++;
                $display("FAIL %s load addr=%h got=%h exp=%h", nm, a, rd, gval(int'(a >> 2)));
            end
        end
        checks++;
        if (wb_addr.size() != exp_wb) begin
            errors++;
            $display("FAIL %s wb_count addr=%h got=%0d exp=%0d", nm, a, wb_addr.size(), exp_wb);
        end else begin
            for (int k = 0; k < exp_wb; k++) begin
                logic [31:0] ea;
                ea = 32'((old_tag << 8) | (idx << 4) | (k << 2));
                checks++;
                if (wb_addr[k] !== ea || wb_data[k] !== gval(int'(ea >> 2))) begin
                    errors++;
                    $display("FAIL %s wb_beat%0d got=%h:%h exp=%h:%h", nm, k, wb_addr[k], wb_data[k], ea, gval(int'(ea >> 2)));
                end
            end
        end
        m_valid[idx] = 1; m_tag[idx] = tg;
        if (exp_low != 0) m_dirty[idx] = 0;
        if (st) begin m_dirty[idx] = 1; gmem[int'(a >> 2)] = d; end
    endtask

    task automatic check_idle_outputs(input string nm);
        checks++;
        if (mem_ready !== 1'b1 || bk_req !== 1'b0 || bk_we !== 1'b0 || bk_addr !== 32'h0 || bk_wdata !== 32'h0) begin
            errors++;
            $display("FAIL %s ready=%b req=%b we=%b addr=%h wdata=%h exp 1 0 0 0 0", nm, mem_ready, bk_req, bk_we, bk_addr, bk_wdata);
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b1; mem_write_en = 0; mem_read_en = 0; mem_addr = '0;
        for (int i = 0; i < 4; i++) mem_data_in[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_during");
        @(posedge clk); #1;
        rst_b = 1'b0;
        model_reset();
        @(negedge clk);
        check_idle_outputs("reset_after");
        @(posedge clk); #1;
    endtask

    task automatic test_load_miss();
        logic [31:0] rd;
        int we0;
        we0 = we_cycles;
        run_op("load_miss", 32'h100, 0, 0, 0, rd);
        checks++;
        if (rd !== 32'hA5A5_0040 || we_cycles != we0) begin
            errors++;
            $display("FAIL load_miss_fixed data=%h exp=a5a50040 we_cycles=%0d exp 0", rd, we_cycles - we0);
        end
    endtask

    task automatic test_load_hit();
        logic [31:0] rd;
        int r0;
        r0 = req_cycles;
        run_op("load_hit", 32'h104, 0, 0, 0, rd);
        checks++;
        if (rd !== 32'hA5A5_0041 || req_cycles != r0) begin
            errors++;
            $display("FAIL load_hit_fixed data=%h exp=a5a50041 req_cycles=%0d exp 0", rd, req_cycles - r0);
        end
    endtask

    task automatic test_store_hit();
        logic [31:0] rd;
        logic [7:0] exp_l [4];
        exp_l = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_op("store_hit", 32'h108, 1, 0, 32'hDEAD_BEEF, rd);
        run_op("store_readback", 32'h108, 0, 0, 0, rd);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd[31-8*i -: 8] !== exp_l[i]) begin
                errors++;
                $display("FAIL store_lane%0d got=%h exp=%h", i, rd[31-8*i -: 8], exp_l[i]);
            end
        end
    endtask

    task automatic test_evict();
        logic [31:0] rd;
        run_op("evict", 32'h1108, 0, 0, 0, rd);
        checks++;
        if (bmem[32'h108 >> 2] !== 32'hDEAD_BEEF || rd !== 32'hA5A5_0442) begin
            errors++;
            $display("FAIL evict_fixed mem108=%h exp=deadbeef data=%h exp=a5a50442", bmem[32'h108 >> 2], rd);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd;
        int f0, n;
        mem_addr = 32'h100; mem_read_en = 1'b1; mem_write_en = 1'b0;
        f0 = fill_acks; n = 0;
        while (fill_acks - f0 < 2 && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (fill_acks - f0 < 2) begin
            errors++;
            $display("FAIL reset_fill_wait acks=%0d exp 2", fill_acks - f0);
        end
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0; mem_read_en = 1'b0;
        model_reset();
        @(negedge clk);
        check_idle_outputs("reset_fill_abandon");
        @(posedge clk); #1;
        run_op("reload_after_reset", 32'h100, 0, 0, 0, rd);
    endtask

    task automatic test_both_en();
        logic [31:0] rd;
        run_op("both_en_store", 32'h104, 1, 1, 32'h1234_5678, rd);
        run_op("both_en_evict", 32'h2104, 0, 0, 0, rd);
        checks++;
        if (bmem[32'h104 >> 2] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL both_en_wb mem104=%h exp=12345678", bmem[32'h104 >> 2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        for (int k = 0; k < 4; k++) run_op("b2b_hit", 32'h2100 + 32'(4 * k), 0, 0, 0, rd);
        run_op("b2b_store", 32'h2108, 1, 0, 32'hCAFE_F00D, rd);
        run_op("b2b_load", 32'h2108, 0, 0, 0, rd);
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d;
        bit st, both;
        for (int n = 0; n < 150; n++) begin
            a    = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2));
            st   = ($urandom_range(0, 2) == 0);
            both = st && ($urandom_range(0, 3) == 0);
            d    = $urandom;
            run_op("random", a, st, both, d, rd);
        end
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_load_hit();
        test_store_hit();
        test_evict();
        test_reset_mid_fill();
        test_both_en();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
